// File: rtl/sna_flit_injector_if.sv
// Packet, flit and credit signals exchanged between the SNA flit builder,
// the flit injector and the NoC link.
interface sna_flit_injector_if #(
  parameter int FLIT_W = 37,
  parameter int NUM_VC = 8,
  parameter int VC_W   = 3
);
  logic              pkt_valid;
  logic              pkt_ready;
  logic [FLIT_W-1:0] header_in;
  logic [FLIT_W-1:0] tail_in;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_valid;
  logic [VC_W-1:0]   flit_vc;
  logic [NUM_VC-1:0] credit_in;
  logic [NUM_VC-1:0] is_allocatable;
  logic              credit_err;

  // master: builder plus link environment; slave: the injector
  modport master (
    output pkt_valid, header_in, tail_in, credit_in,
    input  pkt_ready, flit_out, flit_valid, flit_vc, is_allocatable, credit_err
  );

  modport slave (
    input  pkt_valid, header_in, tail_in, credit_in,
    output pkt_ready, flit_out, flit_valid, flit_vc, is_allocatable, credit_err
  );
endinterface

// File: rtl/sna_flit_injector.sv
// Two-flit packet injector: round-robin VC allocation under credit flow
// control, then header and tail serialised onto the NoC link.
//
// state | meaning
// IDLE  | ready for a packet from the flit builder
// ALLOC | packet latched, searching for a VC holding >= 2 credits
// HEAD  | header flit on the link
// TAIL  | tail flit on the link
module sna_flit_injector #(
  parameter int FLIT_W         = 37,
  parameter int NUM_VC         = 8,
  parameter int VC_W           = 3,
  parameter int CREDITS_PER_VC = 4,
  parameter int CNT_W          = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  sna_flit_injector_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ALLOC, HEAD, TAIL} state_t;

  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS_PER_VC);
  localparam logic [CNT_W-1:0] PKT_COST   = CNT_W'(2);

  state_t            state;
  logic [FLIT_W-1:0] hdr_q;
  logic [FLIT_W-1:0] tail_q;
  logic [FLIT_W-1:0] flit_q;
  logic [VC_W-1:0]   vc_q;
  logic [VC_W-1:0]   rr_ptr;
  logic              pkt_ready_q;
  logic              flit_valid_q;
  logic              credit_err_q;

  logic [CNT_W-1:0]  credit     [NUM_VC];
  logic [CNT_W-1:0]  credit_nxt [NUM_VC];
  logic [NUM_VC-1:0] eligible;
  logic [NUM_VC-1:0] dec_vec;
  logic              overflow;
  logic              grant_ok;
  logic [VC_W-1:0]   grant_vc;
  logic              fire;

  function automatic logic [VC_W-1:0] wrap_add(input logic [VC_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_VC) s = s - NUM_VC;
    return VC_W'(s);
  endfunction

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      eligible[i] = (credit[i] >= PKT_COST);
    end
  end

  // First eligible VC at or after rr_ptr, wrapping around.
  always_comb begin
    grant_ok = 1'b0;
    grant_vc = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (!grant_ok && eligible[wrap_add(rr_ptr, k)]) begin
        grant_ok = 1'b1;
        grant_vc = wrap_add(rr_ptr, k);
      end
    end
  end

  assign fire    = (state == ALLOC) && grant_ok;
  assign dec_vec = fire ? (NUM_VC'(1) << grant_vc) : '0;

  // Grant reserves both flits up front; a return on a full counter is an error.
  always_comb begin
    overflow = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      credit_nxt[i] = credit[i];
      if (dec_vec[i]) begin
        credit_nxt[i] = credit[i] - PKT_COST + CNT_W'(bus.credit_in[i]);
      end else if (bus.credit_in[i]) begin
        if (credit[i] == CREDIT_MAX) begin
          overflow = 1'b1;
        end else begin
          credit_nxt[i] = credit[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VC; i++) begin
        credit[i] <= CREDIT_MAX;
      end
      credit_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        credit[i] <= credit_nxt[i];
      end
      if (overflow) credit_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      hdr_q        <= '0;
      tail_q       <= '0;
      flit_q       <= '0;
      vc_q         <= '0;
      rr_ptr       <= '0;
      pkt_ready_q  <= 1'b1;
      flit_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pkt_valid) begin
            hdr_q       <= bus.header_in;
            tail_q      <= bus.tail_in;
            pkt_ready_q <= 1'b0;
            state       <= ALLOC;
          end
        end
        ALLOC: begin
          if (grant_ok) begin
            vc_q         <= grant_vc;
            rr_ptr       <= wrap_add(grant_vc, 1);
            flit_q       <= hdr_q;
            flit_valid_q <= 1'b1;
            state        <= HEAD;
          end
        end
        HEAD: begin
          flit_q <= tail_q;
          state  <= TAIL;
        end
        TAIL: begin
          flit_valid_q <= 1'b0;
          pkt_ready_q  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pkt_ready      = pkt_ready_q;
  assign bus.flit_out       = flit_q;
  assign bus.flit_valid     = flit_valid_q;
  assign bus.flit_vc        = vc_q;
  assign bus.is_allocatable = eligible;
  assign bus.credit_err     = credit_err_q;

endmodule

// File: tb/tb_sna_flit_injector.sv
// Bench for sna_flit_injector: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.
module tb_sna_flit_injector;
  localparam int FLIT_W = 37;
  localparam int NUM_VC = 8;
  localparam int VC_W   = 3;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  sna_flit_injector_if #(.FLIT_W(FLIT_W), .NUM_VC(NUM_VC), .VC_W(VC_W)) bus ();

  sna_flit_injector #(
    .FLIT_W(FLIT_W), .NUM_VC(NUM_VC), .VC_W(VC_W),
    .CREDITS_PER_VC(4), .CNT_W(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [FLIT_W-1:0] flit;
    logic [VC_W-1:0]   vc;
  } exp_t;

  exp_t              m_q[$];
  int                m_credit[NUM_VC];
  int                m_rr;
  bit                m_err;
  bit                m_pend;
  bit                m_live = 0;
  logic [FLIT_W-1:0] m_hdr, m_tail;
  logic [FLIT_W-1:0] m_last_flit;
  logic [VC_W-1:0]   m_last_vc;
  bit                m_ready_old;
  int                m_g;
  int                m_inc, m_dec, m_v;

  function automatic logic [NUM_VC-1:0] model_alloc();
    logic [NUM_VC-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_VC; i++) r[i] = (m_credit[i] >= 2);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live = 1;
      for (int i = 0; i < NUM_VC; i++) m_credit[i] = 4;
      m_rr = 0; m_err = 0; m_pend = 0;
      m_q.delete();
      m_last_flit = '0; m_last_vc = '0;
    end else if (m_live) begin
      m_ready_old = !m_pend && (m_q.size() == 0);
      m_g = -1;
      if (m_pend) begin
        for (int k = 0; k < NUM_VC; k++) begin
          m_v = (m_rr + k) % NUM_VC;
          if (m_g < 0 && m_credit[m_v] >= 2) m_g = m_v;
        end
      end
      if (m_q.size() > 0) void'(m_q.pop_front());
      for (int i = 0; i < NUM_VC; i++) begin
        m_inc = bus.credit_in[i] ? 1 : 0;
        m_dec = (i == m_g) ? 2 : 0;
        if (m_credit[i] == 4 && m_inc == 1 && m_dec == 0) m_err = 1;
        else m_credit[i] = m_credit[i] + m_inc - m_dec;
      end
      if (m_g >= 0) begin
        m_q.push_back('{flit: m_hdr,  vc: VC_W'(m_g)});
        m_q.push_back('{flit: m_tail, vc: VC_W'(m_g)});
        m_rr   = (m_g + 1) % NUM_VC;
        m_pend = 0;
      end
      if (m_ready_old && bus.pkt_valid) begin
        m_pend = 1;
        m_hdr  = bus.header_in;
        m_tail = bus.tail_in;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      if (m_q.size() > 0) begin
        m_last_flit = m_q[0].flit;
        m_last_vc   = m_q[0].vc;
      end
      chk("m_flit_valid", bus.flit_valid, (m_q.size() > 0));
      chk("m_flit_out", bus.flit_out, m_last_flit);
      chk("m_flit_vc", bus.flit_vc, m_last_vc);
      chk("m_pkt_ready", bus.pkt_ready, (!m_pend && m_q.size() == 0));
      chk("m_is_allocatable", bus.is_allocatable, model_alloc());
      chk("m_credit_err", bus.credit_err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Returns just after the accept edge.
  task automatic send_pkt(input logic [FLIT_W-1:0] h, input logic [FLIT_W-1:0] t);
    int n;
    n = 0;
    while (bus.pkt_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait", bus.pkt_ready, 1'b1);
    bus.pkt_valid = 1'b1;
    bus.header_in = h;
    bus.tail_in   = t;
    tick();
    bus.pkt_valid = 1'b0;
  endtask

  function automatic logic [FLIT_W-1:0] rnd_flit();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[FLIT_W-1:0];
  endfunction

  initial begin
    logic [FLIT_W-1:0] h, t;
    bus.pkt_valid = 1'b0;
    bus.header_in = '0;
    bus.tail_in   = '0;
    bus.credit_in = '0;

    // reset state
    do_reset();
    chk("rst_flit_valid", bus.flit_valid, 1'b0);
    chk("rst_pkt_ready", bus.pkt_ready, 1'b1);
    chk("rst_alloc", bus.is_allocatable, 8'hFF);
    chk("rst_credit_err", bus.credit_err, 1'b0);
    chk("rst_flit_out", bus.flit_out, 0);
    tick();

    // single packet latency
    send_pkt(37'h000000FFFF, 37'h1F00000001);
    chk("p1_ready_busy", bus.pkt_ready, 1'b0);
    tick();
    chk("p1_head_valid", bus.flit_valid, 1'b1);
    chk("p1_head_flit", bus.flit_out, 37'h000000FFFF);
    chk("p1_head_vc", bus.flit_vc, 0);
    tick();
    chk("p1_tail_flit", bus.flit_out, 37'h1F00000001);
    chk("p1_tail_vc", bus.flit_vc, 0);
    tick();
    chk("p1_done_ready", bus.pkt_ready, 1'b1);
    chk("p1_done_valid", bus.flit_valid, 1'b0);
    chk("p1_alloc", bus.is_allocatable, 8'hFF);

    // back-to-back packets go round-robin over VCs 0..3
    do_reset();
    for (int p = 0; p < 4; p++) begin
      h = rnd_flit();
      t = rnd_flit();
      send_pkt(h, t);
      tick();
      chk("b2b_head_vc", bus.flit_vc, p);
      chk("b2b_head_flit", bus.flit_out, h);
      tick();
      chk("b2b_tail_vc", bus.flit_vc, p);
      chk("b2b_tail_flit", bus.flit_out, t);
    end

    // exhaust credits with 12 more packets, then starve the 17th
    for (int p = 0; p < 12; p++) send_pkt(rnd_flit(), rnd_flit());
    while (bus.pkt_ready !== 1'b1) tick();
    chk("drain_alloc", bus.is_allocatable, 8'h00);
    h = 37'h0ABCDE1234;
    send_pkt(h, 37'h0000C0FFEE);
    repeat (3) tick();
    chk("starve_ready", bus.pkt_ready, 1'b0);
    chk("starve_valid", bus.flit_valid, 1'b0);
    bus.credit_in = 8'h08;
    tick();
    tick();
    bus.credit_in = 8'h00;
    chk("starve_alloc", bus.is_allocatable, 8'h08);
    chk("starve_still_idle", bus.flit_valid, 1'b0);
    tick();
    chk("starve_head_valid", bus.flit_valid, 1'b1);
    chk("starve_head_vc", bus.flit_vc, 3);
    chk("starve_head_flit", bus.flit_out, h);

    // grant and return on the same VC net to -1
    do_reset();
    send_pkt(rnd_flit(), rnd_flit());
    bus.credit_in = 8'h01;
    tick();
    bus.credit_in = 8'h00;
    chk("net_vc", bus.flit_vc, 0);
    chk("net_alloc", bus.is_allocatable, 8'hFF);
    repeat (2) tick();
    bus.credit_in = 8'h01;
    tick();
    bus.credit_in = 8'h00;
    chk("net_no_err_at_4", bus.credit_err, 1'b0);
    bus.credit_in = 8'h01;
    tick();
    bus.credit_in = 8'h00;
    chk("net_err_over_4", bus.credit_err, 1'b1);

    // overflow on an idle full VC is sticky
    do_reset();
    chk("ovf_cleared", bus.credit_err, 1'b0);
    bus.credit_in = 8'h20;
    tick();
    bus.credit_in = 8'h00;
    chk("ovf_err", bus.credit_err, 1'b1);
    chk("ovf_alloc", bus.is_allocatable, 8'hFF);
    repeat (5) tick();
    chk("ovf_sticky", bus.credit_err, 1'b1);

    // reset in HEAD drops the packet
    do_reset();
    send_pkt(rnd_flit(), rnd_flit());
    tick();
    chk("rh_head_valid", bus.flit_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rh_valid", bus.flit_valid, 1'b0);
    chk("rh_ready", bus.pkt_ready, 1'b1);
    chk("rh_alloc", bus.is_allocatable, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rh_no_tail", bus.flit_valid, 1'b0);
    end

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [NUM_VC-1:0] cr;
      bus.pkt_valid = ($urandom_range(2) != 0);
      bus.header_in = rnd_flit();
      bus.tail_in   = rnd_flit();
      cr = '0;
      for (int i = 0; i < NUM_VC; i++) cr[i] = ($urandom_range(23) == 0);
      bus.credit_in = cr;
      rst_n = ($urandom_range(499) != 0);
      tick();
    end
    rst_n = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.credit_in = '0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sna_flit_injector.md
Name: sna_flit_injector

Overview:
- Downstream stage of the slave-side NoC adapter (SNA) flit builder.
- Takes each two-flit response packet (header + tail) produced by the builder.
- Allocates an output virtual channel (VC) under credit-based flow control and serialises the packet onto the NoC link, header first, then tail.
- Drives the is_allocatable vector back to the flit builder.

Parameters:
- FLIT_W, 37, flit width in bits; flits are opaque to this block.
- NUM_VC, 8, number of virtual channels.
- VC_W, 3, width of the VC index (clog2 of NUM_VC).
- CREDITS_PER_VC, 4, downstream buffer depth per VC; reset value of every credit counter.
- CNT_W, 3, credit counter width (clog2 of CREDITS_PER_VC+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pkt_valid  in  1  flit builder presents a packet.
- pkt_ready  out  1  injector accepts the packet this cycle.
- header_in  in  FLIT_W  header flit from the builder.
- tail_in  in  FLIT_W  tail flit from the builder.
- flit_out  out  FLIT_W  flit driven to the NoC link.
- flit_valid  out  1  flit_out is valid this cycle.
- flit_vc  out  VC_W  VC carrying flit_out.
- credit_in  in  NUM_VC  per-VC single-cycle credit return pulses; any combination may be high in one cycle.
- is_allocatable  out  NUM_VC  bit i = 1 when credit[i] >= 2; fed to the flit builder.
- credit_err  out  1  sticky flag: a credit was returned to a VC whose counter was already full.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; every credit[i]=CREDITS_PER_VC; rr_ptr=0; credit_err=0.
  - flit_valid=0, flit_out=0, flit_vc=0.
  - One cycle later: pkt_ready=1, is_allocatable=all ones.
  - Reset wins over every other event, including mid-packet; an in-flight packet is dropped, not completed.
- State machine: IDLE -> ALLOC -> HEAD -> TAIL -> IDLE.
- IDLE:
  - pkt_ready=1, and pkt_ready is 0 in every other state.
  - On pkt_valid at an edge: latch header_in and tail_in into internal registers; go to ALLOC.
- ALLOC:
  - Eligible VC = credit >= 2. Both flits are reserved at grant, so the tail can never stall.
  - Round-robin search starts at rr_ptr and takes the first eligible index, wrapping from NUM_VC-1 to 0.
  - On grant: credit[g] -= 2; latch g for flit_vc; rr_ptr <= (g+1) mod NUM_VC; go to HEAD.
  - With no eligible VC: remain in ALLOC, no credit change, flit_valid=0.
- HEAD: flit_valid=1, flit_out=latched header, flit_vc=g; go to TAIL.
- TAIL: flit_valid=1, flit_out=latched tail, flit_vc=g; go to IDLE.
- flit_valid=0 in IDLE and ALLOC; flit_out and flit_vc hold their last value there.
- Latency:
  - Packet accepted at edge T; grant decided at edge T+1.
  - Header valid in cycle T+1..T+2; tail valid in cycle T+2..T+3.
  - pkt_ready=1 again after edge T+3. Peak rate is one packet per 4 cycles.
- Credit update, per VC per edge: new = old + inc - dec, where inc = credit_in[i] and dec = 2 if granted this edge, else 0.
  - A simultaneous return and grant on the same VC nets to -1.
  - If old = CREDITS_PER_VC and inc = 1 and no grant: the counter holds and credit_err <= 1.
  - credit_err clears only on reset.
- is_allocatable is combinational from the credit counters; it reflects a grant or credit return in the cycle after the edge.
- pkt_valid in a non-IDLE state is ignored. header_in and tail_in are sampled only at the accept edge.

Test Plan:
1. Hold rst_n=0 for 2 edges, then release -> flit_valid=0, pkt_ready=1, is_allocatable=8'hFF, credit_err=0.
2. Present header_in=37'h000000FFFF and tail_in=37'h1F00000001 at edge T -> header on flit_out in cycle after T+1 with flit_vc=0, tail in cycle after T+2 with flit_vc=0, pkt_ready=1 after T+3; is_allocatable stays 8'hFF (credit[0]=2).
3. Four back-to-back packets, no credit returns -> flit_vc sequence 0,1,2,3; 8 flits total; each header is immediately followed by its own tail.
4. Send 16 packets with no credit_in -> all credits 0, is_allocatable=8'h00; the 17th packet is accepted and then waits in ALLOC with pkt_ready=0 and flit_valid=0. Then pulse credit_in=8'h08 twice -> is_allocatable=8'h08, and the packet goes out on flit_vc=3.
5. In the grant cycle for VC 0 (credit 4), also pulse credit_in[0] -> credit[0]=3 afterwards. Separately, pulse credit_in[5] while credit[5]=4 -> counter stays 4 and credit_err=1 until reset.
6. Assert rst_n=0 while in HEAD -> next cycle flit_valid=0, no tail is emitted, pkt_ready=1, is_allocatable=8'hFF.
